// File: rtl/sseg_pattern_gen_pkg.sv
// Shared constants and types for the animated seven-segment pattern source.
// All segment patterns are active-low: bit7 = dp, bits 6..0 = g..a.
package sseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_SQ_UP = 8'h9C;
    localparam logic [7:0] SEG_SQ_LO = 8'hA3;

    // Index 0 is the glyph for hex digit 0.
    localparam logic [0:15][7:0] HEX_GLYPH = {
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_SCROLL = 1'b1
    } mode_e;

endpackage

// File: rtl/sseg_pattern_gen_if.sv
// Message load channel: 64-bit message (16 hex digits) offered with valid/ready.
interface sseg_pattern_gen_if;

    logic        msg_valid;
    logic [63:0] msg_data;
    logic        msg_ready;

    modport master (output msg_valid, output msg_data, input msg_ready);
    modport slave  (input msg_valid, input msg_data, output msg_ready);

endinterface

// File: rtl/hex_to_sseg.sv
// Combinational hex-digit to active-low segment decoder; dp = 1 lights the point.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, HEX_GLYPH[hex][6:0]};

endmodule

// File: rtl/sseg_pattern_gen.sv
// Animated rotating-square / scrolling-hex pattern source for the 4-digit mux.
// Optional dp heartbeat on in0 enabled by defining SSEG_PATTERN_GEN_DP_EN.
module sseg_pattern_gen
    import sseg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cw,
    input  logic                 mode,
    sseg_pattern_gen_if.slave    msg,
    output logic                 step,
    output logic [7:0]           in0,
    output logic [7:0]           in1,
    output logic [7:0]           in2,
    output logic [7:0]           in3
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt;
    logic [2:0]    pos;
    logic [3:0]    off;
    logic [63:0]   buffer;
    mode_e         mode_q;
    mode_e         mode_cur;
    logic          accept;
    logic          mode_chg;
    logic          wrap;
    logic          dp_lit;
    logic [7:0]    sq  [4];
    logic [7:0]    sc  [4];
    logic [7:0]    pat [4];

    assign mode_cur      = mode_e'(mode);
    assign msg.msg_ready = !(en && mode) || (off == '0);
    assign accept        = msg.msg_valid && msg.msg_ready;
    assign mode_chg      = (mode_cur != mode_q);
    // Accept and mode change both restart the prescaler, so either one swallows a pending step.
    assign wrap          = en && (cnt == LAST) && !accept && !mode_chg;

`ifdef SSEG_PATTERN_GEN_DP_EN
    logic dp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_q <= 1'b1;
        end else if (wrap) begin
            dp_q <= ~dp_q;
        end
    end

    assign dp_lit = ~dp_q;
`else
    assign dp_lit = 1'b0;
`endif

    always_comb begin
        sq = '{default: SEG_BLANK};
        if (!pos[2]) begin
            sq[2'd3 - pos[1:0]] = SEG_SQ_UP;
        end else begin
            sq[pos[1:0]] = SEG_SQ_LO;
        end
        sq[0][7] = ~dp_lit;
    end

    // Output j shows message digit (off + 3 - j) mod 16; digit k sits at buffer[63-4k -: 4].
    for (genvar j = 0; j < 4; j++) begin : g_dig
        logic [3:0] idx;
        logic [3:0] nib;

        assign idx = off + 4'(3 - j);
        assign nib = buffer[{~idx, 2'b00} +: 4];

        hex_to_sseg u_hex (
            .hex (nib),
            .dp  ((j == 0) ? dp_lit : 1'b0),
            .seg (sc[j])
        );
    end

    always_comb begin
        for (int unsigned j = 0; j < 4; j++) begin
            pat[j] = (mode_cur == MODE_SCROLL) ? sc[j] : sq[j];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pos    <= '0;
            off    <= '0;
            buffer <= '0;
            mode_q <= MODE_SQUARE;
            step   <= 1'b0;
            in0    <= '1;
            in1    <= '1;
            in2    <= '1;
            in3    <= '1;
        end else begin
            mode_q <= mode_cur;
            step   <= wrap;
            in0    <= pat[0];
            in1    <= pat[1];
            in2    <= pat[2];
            in3    <= pat[3];

            if (accept) begin
                buffer <= msg.msg_data;
                off    <= '0;
                cnt    <= '0;
            end else if (mode_chg) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
                if (wrap) begin
                    if (mode_cur == MODE_SQUARE) begin
                        pos <= cw ? pos + 3'd1 : pos - 3'd1;
                    end else begin
                        off <= cw ? off + 4'd1 : off - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sseg_pattern_gen.md
# sseg_pattern_gen

Animated segment-pattern source that feeds the 4-digit seven-segment display multiplexer. It produces four registered 8-bit active-low segment patterns (`in0`..`in3`, `in0` = rightmost digit) that the multiplexer scans onto the display. Two animations are supported: a rotating square and a scrolling 16-digit hex message. New messages are loaded through a valid/ready handshake.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per animation step. Minimum 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  animation enable. When low, the prescaler and position both hold.
- `cw`  in  1  direction. 1 = position increments, 0 = position decrements.
- `mode`  in  1  0 = rotating square, 1 = hex scroll.
- `msg_valid`  in  1  message offer.
- `msg_data`  in  64  16 hex digits. Digit k = `msg_data[63-4k -: 4]`, so digit 0 is leftmost.
- `msg_ready`  out  1  message can be accepted this cycle.
- `step`  out  1  one-cycle pulse on each animation step.
- `in0`, `in1`, `in2`, `in3`  out  8 each  segment patterns. Bit7 = dp, bits 6..0 = g..a. Active-low (0 = lit).

## Operation
- **Segment constants:**
  - BLANK = 8'hFF
  - SQ_UP (segments a, b, f, g) = 8'h9C
  - SQ_LO (segments c, d, e, g) = 8'hA3
  - Hex glyphs 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E
- **Prescaler:** counts 0..TICK_DIV-1 while `en`=1. When it wraps, a step occurs.
- **Mode 0, square position p (3 bits, mod 8):**
  - p=0..3: SQ_UP on in3, in2, in1, in0 respectively.
  - p=4..7: SQ_LO on in0, in1, in2, in3 respectively.
  - All other digits show BLANK.
  - On each step: `cw`=1 → p+1, `cw`=0 → p-1. Both wrap mod 8.
- **Mode 1, scroll offset o (4 bits, mod 16):**
  - in3 = glyph(digit[o]), in2 = glyph(digit[o+1]), in1 = glyph(digit[o+2]), in0 = glyph(digit[o+3]). All indices wrap mod 16.
  - On each step: o±1 mod 16, direction per `cw`.
- **Mode change:** clears the prescaler. p and o are retained. The new mode's pattern appears on the next output update.
- **Handshake:**
  - `msg_ready` = !(`en` && `mode`) || (o==0). This is combinational from registered state.
  - Accept occurs when `msg_valid` && `msg_ready`. On accept: the buffer is loaded, o is set to 0, and the prescaler is cleared.
- **Simultaneous accept and step:** accept wins. The step is suppressed, with no `step` pulse and no position change.
- **Reset values:** in0..in3 = 8'hFF, `step`=0, `msg_ready`=1, p=0, o=0, buffer=0, prescaler=0, dp toggle=1.

## Timing
- `step` is registered. It is high for exactly one cycle: the cycle after the prescaler sits at TICK_DIV-1. p/o update on that same edge.
- in0..in3 are registered from p/o/buffer/mode. The new pattern is visible one cycle after `step` rises, and one cycle after an accept.
- The first valid pattern appears in the second cycle after reset deasserts (p=0 → in3=9C). This holds regardless of `en`.
- `en` falling holds the prescaler, p, o, and the outputs. Nothing is lost when `en` is low.
- Reset mid-animation or mid-load returns immediately (asynchronously) to the reset values. A partially offered message is discarded.
- With `en`=1 and `mode`=1, `msg_ready` is low for 15 of every 16 steps, so a new message enters only at the message boundary.

## Configuration
- `SSEG_PATTERN_GEN_DP_EN`:
  - **Defined:** a dp toggle register flips on every `step`. Bit7 of `in0` follows it in both modes (0 = lit), producing a heartbeat. Its reset value is 1.
  - **Undefined:** bit7 of all outputs is constant 1 and no toggle register exists.

## Structure
- Package `sseg_pkg` holds: SEG_BLANK, SEG_SQ_UP, SEG_SQ_LO, the 16-entry hex glyph constant array, and the mode enumeration (MODE_SQUARE=0, MODE_SCROLL=1).
- Sub-module `hex_to_sseg`: combinational. Takes a 4-bit hex value and a 1-bit dp, and outputs the 8-bit active-low pattern. Instantiate it four times, one per digit, in scroll mode.
- Prescaler width is $clog2(TICK_DIV).

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** assert `reset` mid-run → in0..in3=FF, `msg_ready`=1, `step`=0 immediately. Two cycles after deassert → in3=9C, others FF.
- **Square, cw:** `mode`=0, `en`=1, `cw`=1 → `step` pulses every 4 cycles.
  - After step 1: in2=9C.
  - After step 4: in0=A3.
  - After step 8: in3=9C again.
- **Square, ccw:** from p=0 with `cw`=0, one step → in3=A3 and other digits FF. Then drop `en` for 20 cycles → outputs and `step` stay unchanged.
- **Scroll load:** `mode`=1, offer 64'h0123456789ABCDEF.
  - Accept → in3=C0, in2=F9, in1=A4, in0=B0.
  - After one step: in3=F9 and `msg_ready`=0.
  - After 16 steps: `msg_ready`=1.
- **Scroll wrap:** at o=14 → in3=86, in2=8E, in1=C0, in0=F9.
- **Step collision:** `msg_valid` asserted in the step cycle → no `step` pulse, o=0, and the next step comes 4 cycles later.
- **Heartbeat:** with `SSEG_PATTERN_GEN_DP_EN` defined, `in0[7]` alternates 0/1 on successive steps. Without the macro, `in0[7]` stays 1.
